// File: rtl/rib_slice_if.sv
// rib_slice_if: RIB bus bundle (request payload, req/gnt, response data, rsp/rdy).
// Ports by modport:
//   master: drives addr/wrcs/mask/wdata/req and rdy; receives gnt/rdata/rsp
//   slave : receives addr/wrcs/mask/wdata/req and rdy; drives gnt/rdata/rsp
interface rib_slice_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic [AW-1:0]   addr;
   logic            wrcs;
   logic [DW/8-1:0] mask;
   logic [DW-1:0]   wdata;
   logic            req;
   logic            gnt;
   logic [DW-1:0]   rdata;
   logic            rsp;
   logic            rdy;
   modport master (output addr, wrcs, mask, wdata, req, rdy, input gnt, rdata, rsp);
   modport slave (input addr, wrcs, mask, wdata, req, rdy, output gnt, rdata, rsp);
endinterface

// File: rtl/rib_slice.sv
// rib_slice: registered RIB pipeline slice with an outstanding-request cap.
// Ports:
//   i_clk  clock, rising edge
//   i_rst  synchronous reset, active-high
//   ribs   upstream side (core master connects here)
//   ribm   downstream side (peripheral slave connects here)
// Macro RIB_SLICE_RSP_PIPE_EN: when defined, the response channel is registered
// through a 2-entry skid; when undefined it is a combinational passthrough.
module rib_slice #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MAX_OUT = 4
) (
   input logic         i_clk,
   input logic         i_rst,
   rib_slice_if.slave  ribs,
   rib_slice_if.master ribm
);
   localparam int MW = DW / 8;
   localparam int PW = AW + 1 + MW + DW;
   localparam int CW = $clog2(MAX_OUT + 1);
   localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);
   logic [PW-1:0] in_pld, main_q, main_d, skid_q, skid_d;
   logic          main_v_q, main_v_d, skid_v_q, skid_v_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          acc, iss, ld, rhs;
   assign in_pld = {ribs.addr, ribs.wrcs, ribs.mask, ribs.wdata};
   assign {ribm.addr, ribm.wrcs, ribm.mask, ribm.wdata} = main_q;
   assign ribs.gnt = ~skid_v_q & ~i_rst;
   assign ribm.req = main_v_q & (cnt_q < MAX_C) & ~i_rst;
   assign acc = ribs.req & ribs.gnt;
   assign iss = ribm.req & ribm.gnt;
   assign rhs = ribm.rsp & ribm.rdy;
   // MAIN can take a new entry when empty or when its current one leaves this cycle
   assign ld = ~main_v_q | iss;
   always_comb begin
      main_v_d = ld ? (skid_v_q | acc) : 1'b1;
      main_d   = ld ? (skid_v_q ? skid_q : in_pld) : main_q;
      skid_v_d = ld ? 1'b0 : (skid_v_q | acc);
      skid_d   = (~ld & acc) ? in_pld : skid_q;
      // a response with nothing outstanding is absorbed without underflow
      cnt_d    = (iss & ~rhs) ? cnt_q + 1'b1 :
                 (rhs & ~iss & (cnt_q != '0)) ? cnt_q - 1'b1 : cnt_q;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         main_v_q <= 1'b0;
         skid_v_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         main_v_q <= main_v_d;
         skid_v_q <= skid_v_d;
         cnt_q    <= cnt_d;
      end
      main_q <= main_d;
      skid_q <= skid_d;
   end
`ifdef RIB_SLICE_RSP_PIPE_EN
   logic [DW-1:0] rmain_q, rmain_d, rskid_q, rskid_d;
   logic          rmain_v_q, rmain_v_d, rskid_v_q, rskid_v_d, rld;
   assign ribm.rdy   = ~rskid_v_q;
   assign ribs.rsp   = rmain_v_q;
   assign ribs.rdata = rmain_q;
   assign rld = ~rmain_v_q | ribs.rdy;
   always_comb begin
      rmain_v_d = rld ? (rskid_v_q | rhs) : 1'b1;
      rmain_d   = rld ? (rskid_v_q ? rskid_q : ribm.rdata) : rmain_q;
      rskid_v_d = rld ? 1'b0 : (rskid_v_q | rhs);
      rskid_d   = (~rld & rhs) ? ribm.rdata : rskid_q;
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         rmain_v_q <= 1'b0;
         rskid_v_q <= 1'b0;
      end else begin
         rmain_v_q <= rmain_v_d;
         rskid_v_q <= rskid_v_d;
      end
      rmain_q <= rmain_d;
      rskid_q <= rskid_d;
   end
`else
   assign ribm.rdy   = ribs.rdy;
   assign ribs.rsp   = ribm.rsp;
   assign ribs.rdata = ribm.rdata;
`endif
endmodule

// File: tb/tb_rib_slice.sv
// tb_rib_slice: self-checking bench for rib_slice against a queue-based reference model.
// Works with RIB_SLICE_RSP_PIPE_EN defined or undefined.
module tb_rib_slice;
   localparam int MAX_OUT = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   rib_slice_if #(.AW(32), .DW(32)) s_if ();
   rib_slice_if #(.AW(32), .DW(32)) m_if ();
   rib_slice #(.AW(32), .DW(32), .MAX_OUT(MAX_OUT)) dut (
      .i_clk(clk), .i_rst(rst), .ribs(s_if), .ribm(m_if)
   );
   always #5 clk = ~clk;
   // reference model: items held in the slice, downstream outstanding count, buffered responses
   logic [68:0] held[$];
   logic [68:0] pend[$];
   logic [31:0] rbuf[$];
   int          outs = 0;
   function automatic logic [68:0] pld(logic [31:0] a, logic w, logic [3:0] m, logic [31:0] d);
      return {a, w, m, d};
   endfunction
   function automatic bit e_gnt();
      return !rst && held.size() < 2;
   endfunction
   function automatic bit e_req();
      return !rst && held.size() > 0 && outs < MAX_OUT;
   endfunction
   function automatic bit e_rdy();
`ifdef RIB_SLICE_RSP_PIPE_EN
      return rbuf.size() < 2;
`else
      return s_if.rdy;
`endif
   endfunction
   function automatic bit e_rsp();
`ifdef RIB_SLICE_RSP_PIPE_EN
      return rbuf.size() > 0;
`else
      return m_if.rsp;
`endif
   endfunction
   function automatic logic [31:0] e_rdata();
`ifdef RIB_SLICE_RSP_PIPE_EN
      return rbuf.size() > 0 ? rbuf[0] : 32'h0;
`else
      return m_if.rdata;
`endif
   endfunction
   task automatic mdl();
      bit g, iss, rh;
      g   = e_gnt();
      iss = e_req() && m_if.gnt;
      rh  = m_if.rsp && e_rdy();
      if (rst) begin
         held.delete();
         rbuf.delete();
         outs = 0;
         return;
      end
`ifdef RIB_SLICE_RSP_PIPE_EN
      if (e_rsp() && s_if.rdy) void'(rbuf.pop_front());
      if (rh) rbuf.push_back(m_if.rdata);
`endif
      if (iss) void'(held.pop_front());
      if (s_if.req && g) held.push_back({s_if.addr, s_if.wrcs, s_if.mask, s_if.wdata});
      if (iss && !rh) outs++;
      else if (rh && !iss && outs > 0) outs--;
   endtask
   task automatic drv();
      s_if.req = pend.size() > 0;
      {s_if.addr, s_if.wrcs, s_if.mask, s_if.wdata} = pend.size() > 0 ? pend[0] : 69'h0;
   endtask
   task automatic adv();
      if (s_if.req && s_if.gnt) void'(pend.pop_front());
      mdl();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      m_if.gnt = 1'b0;
      m_if.rsp = 1'b0;
      m_if.rdata = 32'h0;
      s_if.rdy = 1'b1;
   endtask
   task automatic do_reset();
      rst = 1'b1;
      pend.delete();
      idle();
      drv();
      @(negedge clk);
      adv();
      rst = 1'b0;
   endtask
   task automatic test_reset();
      rst = 1'b1;
      idle();
      pend.delete();
      for (int c = 0; c < 2; c++) begin
         drv();
         s_if.req = 1'b1;
         @(negedge clk);
         checks++; if (s_if.gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got %b exp 0", s_if.gnt); end
         checks++; if (m_if.req !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", m_if.req); end
         adv();
      end
      rst = 1'b0;
      drv();
      @(negedge clk);
      checks++; if (m_if.req !== 1'b0) begin errors++; $display("FAIL post_rst_req got %b exp 0", m_if.req); end
      checks++; if (s_if.rsp !== 1'b0) begin errors++; $display("FAIL post_rst_rsp got %b exp 0", s_if.rsp); end
      checks++; if (s_if.gnt !== 1'b1) begin errors++; $display("FAIL post_rst_gnt got %b exp 1", s_if.gnt); end
      checks++; if (m_if.rdy !== 1'b1) begin errors++; $display("FAIL post_rst_rdy got %b exp 1", m_if.rdy); end
      adv();
   endtask
   task automatic test_single_write();
      do_reset();
      m_if.gnt = 1'b1;
      pend.push_back(pld(32'hF100_0000, 1'b1, 4'h1, 32'h55));
      drv();
      @(negedge clk);
      checks++; if (s_if.gnt !== 1'b1) begin errors++; $display("FAIL wr_gnt got %b exp 1", s_if.gnt); end
      checks++; if (m_if.req !== 1'b0) begin errors++; $display("FAIL wr_req0 got %b exp 0", m_if.req); end
      adv();
      drv();
      @(negedge clk);
      checks++; if (m_if.req !== 1'b1) begin errors++; $display("FAIL wr_req1 got %b exp 1", m_if.req); end
      checks++; if (m_if.addr !== 32'hF100_0000) begin errors++; $display("FAIL wr_addr got %h exp f1000000", m_if.addr); end
      checks++; if (m_if.wdata !== 32'h55 || m_if.mask !== 4'h1 || m_if.wrcs !== 1'b1)
         begin errors++; $display("FAIL wr_pld got %h/%h/%b exp 55/1/1", m_if.wdata, m_if.mask, m_if.wrcs); end
      adv();
      drv();
      @(negedge clk);
      checks++; if (m_if.req !== 1'b0) begin errors++; $display("FAIL wr_req2 got %b exp 0", m_if.req); end
      adv();
   endtask
   task automatic test_back_to_back();
      int ni = 0, nr = 0, ng = 0;
      do_reset();
      m_if.gnt = 1'b1;
      for (int i = 0; i < 4; i++) pend.push_back(pld(32'hF200_0000 + 32'(4 * i), 1'b0, 4'hF, 32'h0));
      for (int c = 0; c < 12; c++) begin
         m_if.rsp = ni > nr;
         m_if.rdata = 32'hA0 + 32'(nr);
         drv();
         @(negedge clk);
         if (c < 4) begin
            checks++; if (s_if.gnt !== 1'b1) begin errors++; $display("FAIL b2b_gnt c%0d got %b exp 1", c, s_if.gnt); end
         end
         if (m_if.req && m_if.gnt) begin
            checks++; if (m_if.addr !== 32'hF200_0000 + 32'(4 * ni))
               begin errors++; $display("FAIL b2b_addr got %h exp %h", m_if.addr, 32'hF200_0000 + 32'(4 * ni)); end
            ni++;
         end
         if (m_if.rsp && m_if.rdy) nr++;
         if (s_if.rsp && s_if.rdy) begin
            checks++; if (s_if.rdata !== 32'hA0 + 32'(ng))
               begin errors++; $display("FAIL b2b_rdata got %h exp %h", s_if.rdata, 32'hA0 + 32'(ng)); end
            ng++;
         end
         adv();
      end
      m_if.rsp = 1'b0;
      checks++; if (ni != 4) begin errors++; $display("FAIL b2b_issued got %0d exp 4", ni); end
      checks++; if (ng != 4) begin errors++; $display("FAIL b2b_rsps got %0d exp 4", ng); end
   endtask
   task automatic test_stall();
      int n = 0;
      do_reset();
      for (int i = 0; i < 3; i++) pend.push_back(pld(32'h3000_0000 + 32'(16 * i), 1'b1, 4'hF, 32'(i)));
      for (int c = 0; c < 12; c++) begin
         m_if.gnt = c >= 5;
         drv();
         @(negedge clk);
         if (c < 5) begin
            checks++; if (s_if.gnt !== (c < 2)) begin errors++; $display("FAIL stall_gnt c%0d got %b exp %b", c, s_if.gnt, c < 2); end
            checks++; if (m_if.req !== (c >= 1)) begin errors++; $display("FAIL stall_req c%0d got %b exp %b", c, m_if.req, c >= 1); end
         end
         if (m_if.req && m_if.gnt) begin
            checks++; if (m_if.addr !== 32'h3000_0000 + 32'(16 * n))
               begin errors++; $display("FAIL stall_order got %h exp %h", m_if.addr, 32'h3000_0000 + 32'(16 * n)); end
            n++;
         end
         adv();
      end
      checks++; if (n != 3) begin errors++; $display("FAIL stall_count got %0d exp 3", n); end
   endtask
   task automatic test_max_out();
      int hs = 0, hs2 = 0;
      do_reset();
      m_if.gnt = 1'b1;
      for (int i = 0; i < 6; i++) pend.push_back(pld(32'h4000_0000 + 32'(i), 1'b0, 4'hF, 32'h0));
      for (int c = 0; c < 10; c++) begin
         drv();
         @(negedge clk);
         if (m_if.req && m_if.gnt) hs++;
         adv();
      end
      checks++; if (hs != 4) begin errors++; $display("FAIL max_grants got %0d exp 4", hs); end
      m_if.rsp = 1'b1;
      m_if.rdata = 32'h77;
      drv();
      @(negedge clk);
      checks++; if (m_if.req !== 1'b0) begin errors++; $display("FAIL max_req_capped got %b exp 0", m_if.req); end
      checks++; if (m_if.rdy !== 1'b1) begin errors++; $display("FAIL max_rdy got %b exp 1", m_if.rdy); end
      adv();
      m_if.rsp = 1'b0;
      for (int c = 0; c < 5; c++) begin
         drv();
         @(negedge clk);
         if (c == 0) begin
            checks++; if (m_if.req !== 1'b1) begin errors++; $display("FAIL max_reissue got %b exp 1", m_if.req); end
         end
         if (m_if.req && m_if.gnt) hs2++;
         adv();
      end
      checks++; if (hs2 != 1) begin errors++; $display("FAIL max_one_more got %0d exp 1", hs2); end
   endtask
   task automatic test_reset_mid();
      int hs = 0;
      do_reset();
      m_if.gnt = 1'b1;
      for (int i = 0; i < 3; i++) pend.push_back(pld(32'h5000_0000 + 32'(i), 1'b0, 4'hF, 32'h0));
      for (int c = 0; c < 4; c++) begin
         drv();
         @(negedge clk);
         if (m_if.req && m_if.gnt) hs++;
         adv();
      end
      checks++; if (hs != 3) begin errors++; $display("FAIL mid_fill got %0d exp 3", hs); end
      m_if.gnt = 1'b0;
      for (int i = 0; i < 2; i++) pend.push_back(pld(32'h5100_0000 + 32'(i), 1'b1, 4'hF, 32'h0));
      for (int c = 0; c < 3; c++) begin
         drv();
         @(negedge clk);
         adv();
      end
      drv();
      @(negedge clk);
      checks++; if (s_if.gnt !== 1'b0) begin errors++; $display("FAIL mid_full_gnt got %b exp 0", s_if.gnt); end
      rst = 1'b1;
      #1;
      checks++; if (m_if.req !== 1'b0) begin errors++; $display("FAIL mid_rst_req got %b exp 0", m_if.req); end
      pend.delete();
      drv();
      adv();
      rst = 1'b0;
      drv();
      @(negedge clk);
      checks++; if (m_if.req !== 1'b0) begin errors++; $display("FAIL mid_after_req got %b exp 0", m_if.req); end
      checks++; if (s_if.rsp !== 1'b0) begin errors++; $display("FAIL mid_after_rsp got %b exp 0", s_if.rsp); end
      checks++; if (s_if.gnt !== 1'b1) begin errors++; $display("FAIL mid_after_gnt got %b exp 1", s_if.gnt); end
      adv();
      m_if.rsp = 1'b1;
      m_if.rdata = 32'h99;
      drv();
      @(negedge clk);
      adv();
      m_if.rsp = 1'b0;
      m_if.gnt = 1'b1;
      hs = 0;
      for (int i = 0; i < 6; i++) pend.push_back(pld(32'h5200_0000 + 32'(i), 1'b0, 4'hF, 32'h0));
      for (int c = 0; c < 12; c++) begin
         drv();
         @(negedge clk);
         if (m_if.req && m_if.gnt) hs++;
         adv();
      end
      checks++; if (hs != MAX_OUT) begin errors++; $display("FAIL mid_no_underflow got %0d exp %0d", hs, MAX_OUT); end
   endtask
   task automatic test_rsp_backpressure();
      int n = 0;
      do_reset();
      s_if.rdy = 1'b0;
      for (int c = 0; c < 4; c++) begin
         m_if.rsp = 1'b1;
         m_if.rdata = 32'h1234 + 32'(c);
         drv();
         @(negedge clk);
`ifdef RIB_SLICE_RSP_PIPE_EN
         checks++; if (m_if.rdy !== (c < 2)) begin errors++; $display("FAIL bp_rdy c%0d got %b exp %b", c, m_if.rdy, c < 2); end
         if (c >= 1) begin
            checks++; if (s_if.rsp !== 1'b1 || s_if.rdata !== 32'h1234)
               begin errors++; $display("FAIL bp_hold c%0d got %b/%h exp 1/1234", c, s_if.rsp, s_if.rdata); end
         end
`else
         checks++; if (m_if.rdy !== 1'b0) begin errors++; $display("FAIL bp_rdy c%0d got %b exp 0", c, m_if.rdy); end
         checks++; if (s_if.rsp !== 1'b1 || s_if.rdata !== 32'h1234 + 32'(c))
            begin errors++; $display("FAIL bp_pass c%0d got %b/%h exp 1/%h", c, s_if.rsp, s_if.rdata, 32'h1234 + 32'(c)); end
`endif
         adv();
      end
      m_if.rsp = 1'b0;
      s_if.rdy = 1'b1;
      for (int c = 0; c < 4; c++) begin
         drv();
         @(negedge clk);
         if (s_if.rsp && s_if.rdy) begin
            checks++; if (s_if.rdata !== 32'h1234 + 32'(n))
               begin errors++; $display("FAIL bp_drain got %h exp %h", s_if.rdata, 32'h1234 + 32'(n)); end
            n++;
         end
         adv();
      end
`ifdef RIB_SLICE_RSP_PIPE_EN
      checks++; if (n != 2) begin errors++; $display("FAIL bp_count got %0d exp 2", n); end
`else
      checks++; if (n != 0) begin errors++; $display("FAIL bp_count got %0d exp 0", n); end
`endif
   endtask
   task automatic test_random();
      do_reset();
      for (int c = 0; c < 600; c++) begin
         if (pend.size() < 3 && $urandom_range(0, 1) == 1)
            pend.push_back(pld($urandom, 1'($urandom), 4'($urandom), $urandom));
         m_if.gnt = $urandom_range(0, 3) != 0;
         m_if.rsp = outs > 0 ? $urandom_range(0, 1) == 1 : $urandom_range(0, 7) == 0;
         m_if.rdata = $urandom;
         s_if.rdy = $urandom_range(0, 3) != 0;
         drv();
         @(negedge clk);
         checks++; if (s_if.gnt !== e_gnt()) begin errors++; $display("FAIL rnd_gnt c%0d got %b exp %b", c, s_if.gnt, e_gnt()); end
         checks++; if (m_if.req !== e_req()) begin errors++; $display("FAIL rnd_req c%0d got %b exp %b", c, m_if.req, e_req()); end
         if (e_req()) begin
            checks++; if ({m_if.addr, m_if.wrcs, m_if.mask, m_if.wdata} !== held[0])
               begin errors++; $display("FAIL rnd_pld c%0d got %h exp %h", c, {m_if.addr, m_if.wrcs, m_if.mask, m_if.wdata}, held[0]); end
         end
         checks++; if (m_if.rdy !== e_rdy()) begin errors++; $display("FAIL rnd_rdy c%0d got %b exp %b", c, m_if.rdy, e_rdy()); end
         checks++; if (s_if.rsp !== e_rsp()) begin errors++; $display("FAIL rnd_rsp c%0d got %b exp %b", c, s_if.rsp, e_rsp()); end
         if (e_rsp()) begin
            checks++; if (s_if.rdata !== e_rdata()) begin errors++; $display("FAIL rnd_rdata c%0d got %h exp %h", c, s_if.rdata, e_rdata()); end
         end
         adv();
      end
   endtask
   initial begin
      idle();
      drv();
      test_reset();
      test_single_write();
      test_back_to_back();
      test_stall();
      test_max_out();
      test_reset_mid();
      test_rsp_backpressure();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
